// File: rtl/avalon_enforcer.sv
// Avalon-ST framing guard: zero-latency passthrough that drops beats arriving outside a packet,
// closes packets interrupted by a new sop, and pulses a registered indicator for each violation.
module avalon_enforcer #(
  parameter int DATA_WIDTH_IN_BYTES = 16,
  localparam int DW = DATA_WIDTH_IN_BYTES * 8,
  localparam int EW = (DATA_WIDTH_IN_BYTES > 1) ? $clog2(DATA_WIDTH_IN_BYTES) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] untrusted_msg_data,
  input  logic          untrusted_msg_valid,
  output logic          untrusted_msg_rdy,
  input  logic          untrusted_msg_sop,
  input  logic          untrusted_msg_eop,
  input  logic [EW-1:0] untrusted_msg_empty,
  output logic [DW-1:0] enforced_msg_data,
  output logic          enforced_msg_valid,
  input  logic          enforced_msg_rdy,
  output logic          enforced_msg_sop,
  output logic          enforced_msg_eop,
  output logic [EW-1:0] enforced_msg_empty,
  output logic          missing_sop_indi,
  output logic          unexpected_sop_indi
);

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_IN_PKT = 1'b1
  } state_t;

  state_t state_r;
  state_t state_s;
  logic   accept_s;
  logic   missing_s;
  logic   unexpected_s;

  assign untrusted_msg_rdy = enforced_msg_rdy;
  assign enforced_msg_data = untrusted_msg_data;
  assign accept_s          = untrusted_msg_valid & enforced_msg_rdy;

  // Framing decision: next state, cleaned sideband fields and violation detection
  always_comb begin
    state_s            = state_r;
    enforced_msg_valid = 1'b0;
    enforced_msg_sop   = 1'b0;
    enforced_msg_eop   = 1'b0;
    enforced_msg_empty = {EW{1'b0}};
    missing_s          = 1'b0;
    unexpected_s       = 1'b0;
    if (untrusted_msg_valid) begin
      case (state_r)
        ST_IDLE: begin
          if (!untrusted_msg_sop) begin
            missing_s = accept_s;
          end else begin
            enforced_msg_valid = 1'b1;
            enforced_msg_sop   = 1'b1;
            enforced_msg_eop   = untrusted_msg_eop;
            enforced_msg_empty = untrusted_msg_eop ? untrusted_msg_empty : {EW{1'b0}};
            if (!untrusted_msg_eop && accept_s) begin
              state_s = ST_IN_PKT;
            end else begin
              state_s = state_r;
            end
          end
        end
        ST_IN_PKT: begin
          enforced_msg_valid = 1'b1;
          if (untrusted_msg_sop) begin
            // A new sop mid-packet closes the current packet; the new sop is discarded
            enforced_msg_eop = 1'b1;
            if (accept_s) begin
              unexpected_s = 1'b1;
              state_s      = ST_IDLE;
            end else begin
              state_s = state_r;
            end
          end else begin
            enforced_msg_eop   = untrusted_msg_eop;
            enforced_msg_empty = untrusted_msg_eop ? untrusted_msg_empty : {EW{1'b0}};
            if (untrusted_msg_eop && accept_s) begin
              state_s = ST_IDLE;
            end else begin
              state_s = state_r;
            end
          end
        end
        default: begin
          state_s = ST_IDLE;
        end
      endcase
    end else begin
      state_s = state_r;
    end
  end

  // State register and registered violation pulses
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r             <= ST_IDLE;
      missing_sop_indi    <= 1'b0;
      unexpected_sop_indi <= 1'b0;
    end else begin
      state_r             <= state_s;
      missing_sop_indi    <= missing_s;
      unexpected_sop_indi <= unexpected_s;
    end
  end

endmodule

// File: tb/tb_avalon_enforcer.sv
// Directed scoreboard bench for avalon_enforcer: each step pushes its expected output beat and
// indicator values, then pops and checks them once the DUT has produced them.
module tb_avalon_enforcer;

  localparam int NB = 16;
  localparam int DW = NB * 8;
  localparam int EW = 4;

  logic          clk;
  logic          rst;
  logic [DW-1:0] u_data;
  logic          u_valid;
  logic          u_rdy;
  logic          u_sop;
  logic          u_eop;
  logic [EW-1:0] u_empty;
  logic [DW-1:0] e_data;
  logic          e_valid;
  logic          e_rdy;
  logic          e_sop;
  logic          e_eop;
  logic [EW-1:0] e_empty;
  logic          miss;
  logic          unexp;

  typedef struct {
    logic [DW-1:0] data;
    logic          valid;
    logic          sop;
    logic          eop;
    logic [EW-1:0] empty;
    logic          urdy;
    logic          miss;
    logic          unexp;
  } exp_t;

  exp_t sb_q[$];
  int   n_tests;
  int   n_fail;

  avalon_enforcer #(.DATA_WIDTH_IN_BYTES(NB)) dut (
    .clk                (clk),
    .rst                (rst),
    .untrusted_msg_data (u_data),
    .untrusted_msg_valid(u_valid),
    .untrusted_msg_rdy  (u_rdy),
    .untrusted_msg_sop  (u_sop),
    .untrusted_msg_eop  (u_eop),
    .untrusted_msg_empty(u_empty),
    .enforced_msg_data  (e_data),
    .enforced_msg_valid (e_valid),
    .enforced_msg_rdy   (e_rdy),
    .enforced_msg_sop   (e_sop),
    .enforced_msg_eop   (e_eop),
    .enforced_msg_empty (e_empty),
    .missing_sop_indi   (miss),
    .unexpected_sop_indi(unexp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // One beat: drive, push expectation, check combinational outputs, then indicators after the edge
  task automatic step(input string tag, input logic v, input logic s, input logic e,
                      input logic [EW-1:0] emp, input logic [DW-1:0] d, input logic rdy,
                      input logic xv, input logic xs, input logic xe, input logic [EW-1:0] xemp,
                      input logic xmiss, input logic xunexp);
    exp_t x;
    exp_t got;
    u_valid = v; u_sop = s; u_eop = e; u_empty = emp; u_data = d; e_rdy = rdy;
    x.data = d; x.valid = xv; x.sop = xs; x.eop = xe; x.empty = xemp;
    x.urdy = rdy; x.miss = xmiss; x.unexp = xunexp;
    sb_q.push_back(x);
    #2;
    if (sb_q.size() == 0) begin
      n_tests++;
      n_fail++;
      $error("FAIL %s scoreboard empty", tag);
    end else begin
      got = sb_q.pop_front();
      chk({tag, ".data"},  e_data,           got.data);
      chk({tag, ".valid"}, DW'(e_valid),     DW'(got.valid));
      chk({tag, ".sop"},   DW'(e_sop),       DW'(got.sop));
      chk({tag, ".eop"},   DW'(e_eop),       DW'(got.eop));
      chk({tag, ".empty"}, DW'(e_empty),     DW'(got.empty));
      chk({tag, ".urdy"},  DW'(u_rdy),       DW'(got.urdy));
      @(posedge clk);
      #1;
      chk({tag, ".miss"},  DW'(miss),        DW'(got.miss));
      chk({tag, ".unexp"}, DW'(unexp),       DW'(got.unexp));
    end
  endtask

  initial begin
    logic [DW-1:0] d34;
    n_tests = 0;
    n_fail  = 0;
    d34     = {NB{8'd34}};
    rst = 1'b0; u_valid = 1'b0; u_sop = 1'b0; u_eop = 1'b0; u_empty = 4'h0;
    u_data = {DW{1'b0}}; e_rdy = 1'b1;
    #12;
    chk("reset.miss",  DW'(miss),    DW'(1'b0));
    chk("reset.unexp", DW'(unexp),   DW'(1'b0));
    chk("reset.valid", DW'(e_valid), DW'(1'b0));
    rst = 1'b1;
    @(posedge clk);
    #1;

    //    tag        v     sop   eop   emp   data                rdy   xv    xs    xe    xemp  xmiss xunexp
    step("drop0",   1'b1, 1'b0, 1'b0, 4'h0, d34,                1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 1'b1, 1'b0);
    step("drop1",   1'b1, 1'b0, 1'b0, 4'h0, d34,                1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 1'b1, 1'b0);
    step("drop2",   1'b1, 1'b0, 1'b0, 4'h0, d34,                1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 1'b1, 1'b0);
    step("eoponly", 1'b1, 1'b0, 1'b1, 4'h3, {DW{1'b1}},         1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 1'b1, 1'b0);
    step("pkt.sop", 1'b1, 1'b1, 1'b0, 4'h6, DW'(128'h1111),     1'b1, 1'b1, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0);
    step("pkt.mid", 1'b1, 1'b0, 1'b0, 4'h0, DW'(128'h2222),     1'b1, 1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0);
    step("pkt.eop", 1'b1, 1'b0, 1'b1, 4'hF, DW'(128'h3333),     1'b1, 1'b1, 1'b0, 1'b1, 4'hF, 1'b0, 1'b0);
    step("v.sop",   1'b1, 1'b1, 1'b0, 4'h0, DW'(128'hA5A5),     1'b1, 1'b1, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0);
    step("v.usop",  1'b1, 1'b1, 1'b0, 4'h5, DW'(128'h5A5A),     1'b1, 1'b1, 1'b0, 1'b1, 4'h0, 1'b0, 1'b1);
    step("v.drop",  1'b1, 1'b0, 1'b0, 4'h0, DW'(128'h7777),     1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 1'b1, 1'b0);
    step("single",  1'b1, 1'b1, 1'b1, 4'hF, DW'(128'hBEEF),     1'b1, 1'b1, 1'b1, 1'b1, 4'hF, 1'b0, 1'b0);
    step("novalid", 1'b0, 1'b1, 1'b1, 4'hF, DW'(128'hCAFE),     1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0);
    step("bp.hold", 1'b1, 1'b1, 1'b0, 4'h0, DW'(128'hD00D),     1'b0, 1'b1, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0);
    step("bp.acc",  1'b1, 1'b1, 1'b0, 4'h0, DW'(128'hD00D),     1'b1, 1'b1, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0);
    step("bp.mid",  1'b1, 1'b0, 1'b0, 4'h7, DW'(128'hF00D),     1'b1, 1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0);
    step("bp.stl",  1'b1, 1'b1, 1'b1, 4'h2, DW'(128'h4242),     1'b0, 1'b1, 1'b0, 1'b1, 4'h0, 1'b0, 1'b0);

    rst = 1'b0;
    #1;
    chk("rstpkt.miss",  DW'(miss),  DW'(1'b0));
    chk("rstpkt.unexp", DW'(unexp), DW'(1'b0));
    #2;
    rst = 1'b1;
    @(posedge clk);
    #1;
    step("rst.drop", 1'b1, 1'b0, 1'b0, 4'h0, DW'(128'h9999),    1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 1'b1, 1'b0);

    rst = 1'b0;
    #1;
    chk("rstind.miss", DW'(miss), DW'(1'b0));
    #2;
    rst = 1'b1;
    u_valid = 1'b0;
    @(posedge clk);
    #1;

    chk("sb.empty", DW'(sb_q.size()), DW'(0));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
